// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 index tables, shift schedule, FSM codes.
// Bit numbering follows the DES standard (1 = MSB).
package des_pkg;

  localparam int unsigned ROUND_W = 5;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam int unsigned PC1 [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [1:48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int unsigned SHIFT [1:16] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  // 28-bit half rotations; 'one' selects a 1-bit step, otherwise 2 bits.
  function automatic logic [1:28] rot_l(input logic [1:28] h, input logic one);
    return one ? {h[2:28], h[1]} : {h[3:28], h[1:2]};
  endfunction

  function automatic logic [1:28] rot_r(input logic [1:28] h, input logic one);
    return one ? {h[28], h[1:27]} : {h[27:28], h[1:26]};
  endfunction

endpackage

// File: rtl/des_dec_key_sched_if.sv
// Subkey handshake bundle between the key schedule and the Feistel round datapath.
// mode_i exists only when DES_ENC_MODE_EN is defined.
interface des_dec_key_sched_if;

  logic [1:64]                  key_i;
  logic                         start_i;
  logic                         ready_i;
  logic [1:48]                  subkey_o;
  logic [des_pkg::ROUND_W-1:0]  round_o;
  logic                         valid_o;
  logic                         busy_o;
  logic                         done_o;
  logic                         key_err_o;

`ifdef DES_ENC_MODE_EN
  logic                         mode_i;

  modport master (
    output key_i, start_i, ready_i, mode_i,
    input  subkey_o, round_o, valid_o, busy_o, done_o, key_err_o
  );

  modport slave (
    input  key_i, start_i, ready_i, mode_i,
    output subkey_o, round_o, valid_o, busy_o, done_o, key_err_o
  );
`else
  modport master (
    output key_i, start_i, ready_i,
    input  subkey_o, round_o, valid_o, busy_o, done_o, key_err_o
  );

  modport slave (
    input  key_i, start_i, ready_i,
    output subkey_o, round_o, valid_o, busy_o, done_o, key_err_o
  );
`endif

endinterface

// File: rtl/des_pc2_48.sv
// DES PC-2: fixed 56->48 combinational permutation of the concatenated C/D halves.
module des_pc2_48
  import des_pkg::*;
(
  input  logic [1:56] cd,
  output logic [1:48] k
);

  for (genvar i = 1; i <= 48; i++) begin : g_pc2
    assign k[i] = cd[PC2[i]];
  end

endmodule

// File: rtl/des_dec_key_sched.sv
// Iterative DES round-key generator emitting K16..K1 over a valid/ready handshake.
// Optional macro DES_ENC_MODE_EN adds mode_i for encrypt-order (K1..K16) schedules.
module des_dec_key_sched
  import des_pkg::*;
#(
  parameter int unsigned CHECK_PARITY = 0
) (
  input logic               clk,
  input logic               rst,
  des_dec_key_sched_if.slave kif
);

  logic [0:0]         state_q;
  logic [1:28]        c_q, d_q;
  logic [ROUND_W-1:0] round_q;
  logic               done_q;
  logic               err_q;

  logic               enc;
  logic               load_enc;
  logic               valid;
  logic               hs;
  logic               last_round;
  logic [ROUND_W-1:0] shift_idx;
  logic               one_step;
  logic [31:0]        one_mask;
  logic [1:28]        c_step, d_step;
  logic [1:28]        load_c, load_d;
  logic [ROUND_W-1:0] load_round;
  logic [ROUND_W-1:0] round_step;
  logic [1:56]        pc1_key;
  logic [7:0]         byte_even;
  logic               parity_err;
  logic [1:48]        pc2_out;

`ifdef DES_ENC_MODE_EN
  logic enc_q;
  assign enc      = enc_q;
  assign load_enc = kif.mode_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_q <= 1'b0;
    end else if (kif.start_i) begin
      enc_q <= kif.mode_i;
    end
  end
`else
  assign enc      = 1'b0;
  assign load_enc = 1'b0;
`endif

  // PC-1 straight off the key bus; parity bits are dropped here.
  for (genvar i = 1; i <= 56; i++) begin : g_pc1
    assign pc1_key[i] = kif.key_i[PC1[i]];
  end

  for (genvar b = 0; b < 8; b++) begin : g_par
    assign byte_even[b] = ~(^kif.key_i[8*b+1 +: 8]);
  end

  assign parity_err = (CHECK_PARITY != 0) && (|byte_even);

  // Flattened SHIFT table: bit r set when round r uses a single-bit rotation.
  for (genvar r = 0; r < 32; r++) begin : g_shift
    if (r >= 1 && r <= 16) begin : g_tab
      assign one_mask[r] = (SHIFT[r] == 1);
    end else begin : g_pad
      assign one_mask[r] = 1'b0;
    end
  end

  assign valid      = (state_q == ST_ACTIVE);
  assign hs         = valid && kif.ready_i;
  assign last_round = (round_q == (enc ? ROUND_W'(16) : ROUND_W'(1)));

  // Decrypt undoes the shift that produced the current round; encrypt applies the next one.
  assign shift_idx  = enc ? (round_q + ROUND_W'(1)) : round_q;
  assign one_step   = one_mask[shift_idx];
  assign round_step = enc ? (round_q + ROUND_W'(1)) : (round_q - ROUND_W'(1));

  always_comb begin
    c_step = rot_r(c_q, one_step);
    d_step = rot_r(d_q, one_step);
    if (enc) begin
      c_step = rot_l(c_q, one_step);
      d_step = rot_l(d_q, one_step);
    end
  end

  always_comb begin
    load_c     = pc1_key[1:28];
    load_d     = pc1_key[29:56];
    load_round = ROUND_W'(16);
    if (load_enc) begin
      load_c     = rot_l(pc1_key[1:28], 1'b1);
      load_d     = rot_l(pc1_key[29:56], 1'b1);
      load_round = ROUND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (kif.start_i) begin
        state_q <= ST_ACTIVE;
        c_q     <= load_c;
        d_q     <= load_d;
        round_q <= load_round;
        err_q   <= parity_err;
      end else if (hs) begin
        if (last_round) begin
          state_q <= ST_IDLE;
          round_q <= '0;
          done_q  <= 1'b1;
        end else begin
          c_q     <= c_step;
          d_q     <= d_step;
          round_q <= round_step;
        end
      end
    end
  end

  des_pc2_48 u_pc2 (
    .cd ({c_q, d_q}),
    .k  (pc2_out)
  );

  assign kif.subkey_o  = valid ? pc2_out : '0;
  assign kif.round_o   = round_q;
  assign kif.valid_o   = valid;
  assign kif.busy_o    = valid;
  assign kif.done_o    = done_q;
  assign kif.key_err_o = err_q;

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Bench for des_dec_key_sched: transaction-level schedule model checked every cycle,
// plus literal subkey pins from the classic 133457799BBCDFF1 example.
module tb_des_dec_key_sched;

  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFT_T [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;
  localparam logic [63:0] KEY_C = 64'h133457799BBCDFF0;
  localparam logic [63:0] KEY_D = 64'h0101010101010101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  des_dec_key_sched_if kif ();
  des_dec_key_sched_if kifp ();

  assign kifp.key_i   = kif.key_i;
  assign kifp.start_i = kif.start_i;
  assign kifp.ready_i = kif.ready_i;
`ifdef DES_ENC_MODE_EN
  assign kif.mode_i  = 1'b0;
  assign kifp.mode_i = 1'b0;
`endif

  des_dec_key_sched dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  des_dec_key_sched #(.CHECK_PARITY(1)) dut_p (
    .clk (clk),
    .rst (rst),
    .kif (kifp)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int hs_cnt = 0;
  int done_cnt = 0;

  logic [47:0] m_keys [1:16];
  logic [4:0]  m_round = '0;
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  function automatic logic [63:0] model_pc1(input logic [63:0] k);
    logic [63:0] acc = '0;
    for (bit [5:0] i = 0; i < 56; i++)
      acc = (acc << 1) | ((k >> (64 - PC1_T[i])) & 64'd1);
    return acc;
  endfunction

  function automatic logic [47:0] model_pc2(input logic [63:0] cd);
    logic [63:0] acc = '0;
    for (bit [5:0] j = 0; j < 48; j++)
      acc = (acc << 1) | ((cd >> (56 - PC2_T[j])) & 64'd1);
    return acc[47:0];
  endfunction

  function automatic bit parity_bad(input logic [63:0] k);
    bit bad = 1'b0;
    for (bit [3:0] b = 0; b < 8; b++)
      if (($countones((k >> (8 * b)) & 64'hFF) % 2) == 0) bad = 1'b1;
    return bad;
  endfunction

  // Forward (encryption-order) schedule K1..K16; decryption just reads it backwards.
  task automatic build_sched(input logic [63:0] k);
    logic [63:0] cd, c, d;
    int s;
    cd = model_pc1(k);
    c  = cd >> 28;
    d  = cd & 64'hFFFFFFF;
    for (bit [4:0] r = 1; r <= 16; r++) begin
      s = SHIFT_T[r];
      c = ((c << s) | (c >> (28 - s))) & 64'hFFFFFFF;
      d = ((d << s) | (d >> (28 - s))) & 64'hFFFFFFF;
      m_keys[r] = model_pc2((c << 28) | d);
    end
  endtask

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_round  = '0;
      m_err    = 1'b0;
    end else if (kif.start_i) begin
      build_sched(kif.key_i);
      m_active = 1'b1;
      m_round  = 5'd16;
      m_err    = parity_bad(kif.key_i);
    end else if (m_active && kif.ready_i) begin
      if (m_round == 1) begin
        m_active = 1'b0;
        m_round  = '0;
        m_done   = 1'b1;
      end else begin
        m_round = m_round - 5'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [47:0] exp_sub;
      exp_sub = m_active ? m_keys[m_round] : 48'h0;
      chk("valid",     kif.valid_o,    m_active);
      chk("busy",      kif.busy_o,     m_active);
      chk("round",     kif.round_o,    m_round);
      chk("subkey",    kif.subkey_o,   exp_sub);
      chk("done",      kif.done_o,     m_done);
      chk("key_err",   kif.key_err_o,  0);
      chk("p_valid",   kifp.valid_o,   m_active);
      chk("p_round",   kifp.round_o,   m_round);
      chk("p_subkey",  kifp.subkey_o,  exp_sub);
      chk("p_done",    kifp.done_o,    m_done);
      chk("p_key_err", kifp.key_err_o, m_err);
    end
  end

  always @(negedge clk) begin
    if (kif.valid_o === 1'b1 && kif.ready_i === 1'b1) hs_cnt++;
    if (kif.done_o === 1'b1) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_key(input logic [63:0] k);
    kif.key_i   = k;
    kif.start_i = 1'b1;
    tick();
    kif.start_i = 1'b0;
  endtask

  task automatic wait_round(input int r);
    bit ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      if (kif.valid_o === 1'b1 && kif.round_o == r) ok = 1'b1;
      else tick();
    end
    if (!ok) timeout_fail($sformatf("wait_round_%0d", r));
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (kif.done_o === 1'b1) ok = 1'b1;
      else tick();
    end
    if (!ok) timeout_fail("wait_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, d0;
    kif.key_i   = '0;
    kif.start_i = 1'b0;
    kif.ready_i = 1'b0;
    rst = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_valid",  kif.valid_o,  0);
    chk("rst_subkey", kif.subkey_o, 0);
    chk("rst_round",  kif.round_o,  0);
    rst = 1'b0;
    tick();

    // Back-to-back schedule with literal subkeys
    kif.ready_i = 1'b1;
    start_key(KEY_A);
    chk("model_k16", m_keys[16], 48'hCB3D8B0E17F5);
    chk("model_k15", m_keys[15], 48'hBF918D3D3F0A);
    chk("model_k2",  m_keys[2],  48'h79AED9DBC9E5);
    chk("model_k1",  m_keys[1],  48'h1B02EFFC7072);
    chk("lit_r16",   kif.round_o,  16);
    chk("lit_k16",   kif.subkey_o, 48'hCB3D8B0E17F5);
    chk("lit_perr_a", kifp.key_err_o, 0);
    tick();
    chk("lit_r15",   kif.round_o,  15);
    chk("lit_k15",   kif.subkey_o, 48'hBF918D3D3F0A);
    wait_round(2);
    chk("lit_k2",    kif.subkey_o, 48'h79AED9DBC9E5);
    tick();
    chk("lit_r1",    kif.round_o,  1);
    chk("lit_k1",    kif.subkey_o, 48'h1B02EFFC7072);
    tick();
    chk("lit_done",  kif.done_o,   1);
    chk("lit_idle",  kif.valid_o,  0);
    tick();
    chk("lit_done_pulse", kif.done_o, 0);

    // Random backpressure: 16 handshakes, one done
    kif.ready_i = 1'b0;
    hs0 = hs_cnt;
    d0  = done_cnt;
    start_key(KEY_A);
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 300 && !seen; n++) begin
        kif.ready_i = 1'($urandom_range(0, 1));
        tick();
        if (kif.done_o === 1'b1) seen = 1'b1;
      end
      if (!seen) timeout_fail("random_ready_done");
    end
    kif.ready_i = 1'b0;
    tick();
    chk("rand_handshakes", hs_cnt - hs0, 16);
    chk("rand_done_count", done_cnt - d0, 1);

    // Restart at round 9 with a new key
    kif.ready_i = 1'b1;
    d0 = done_cnt;
    start_key(KEY_A);
    wait_round(9);
    kif.key_i   = KEY_B;
    kif.start_i = 1'b1;
    tick();
    kif.start_i = 1'b0;
    chk("restart_round", kif.round_o, 16);
    chk("restart_k16",   kif.subkey_o, m_keys[16]);
    wait_done();
    tick();
    chk("restart_done_count", done_cnt - d0, 1);

    // Reset mid-schedule, then a fresh start
    start_key(KEY_A);
    wait_round(5);
    rst = 1'b1;
    tick();
    chk("midrst_valid",  kif.valid_o,  0);
    chk("midrst_busy",   kif.busy_o,   0);
    chk("midrst_round",  kif.round_o,  0);
    chk("midrst_subkey", kif.subkey_o, 0);
    chk("midrst_done",   kif.done_o,   0);
    rst = 1'b0;
    tick();
    chk("midrst_no_done", kif.done_o, 0);
    start_key(KEY_A);
    chk("after_rst_k16", kif.subkey_o, 48'hCB3D8B0E17F5);
    wait_done();
    tick();

    // Start coincident with final handshake; bad-parity key
    start_key(KEY_A);
    wait_round(1);
    kif.key_i   = KEY_C;
    kif.start_i = 1'b1;
    tick();
    kif.start_i = 1'b0;
    chk("final_restart_round", kif.round_o, 16);
    chk("final_restart_done",  kif.done_o, 0);
    chk("perr_c",        kifp.key_err_o, 1);
    chk("perr_c_off",    kif.key_err_o,  0);
    wait_done();
    tick();
    chk("perr_c_held",   kifp.key_err_o, 1);
    start_key(KEY_D);
    chk("perr_d",        kifp.key_err_o, 0);
    wait_done();
    tick();

    kif.ready_i = 1'b0;
    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
